butterfly_sched: RTL and testbench
==================================

// Module: butterfly_sched
// PURPOSE
//  Scheduler/sequencer for the 4-BU butterfly datapath. Walks one 256-coef polynomial,
//  stored as 32 x 96-bit words (8 coefs/word), through one full operation: NTT/INTT (7 stages)
//  or MULT/ADDSUB (single pass). Drives read/write word addresses, twiddle ROM address and
//  per-word datapath controls, and drains the pipeline between stages.
// PARAMETERS
//  LAT_NTT    7   datapath latency, in_data->out_data, NTT/INTT (cycles)
//  LAT_MULT   11  datapath latency, MULT
//  LAT_ADDSUB 3   datapath latency, ADDSUB
//  WORDS      32  words per polynomial (power of 2)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   synchronous active-low reset
//  start        in   1   pulse: begin operation (ignored while busy)
//  op_mode      in   2   0 NTT, 1 INTT, 2 MULT, 3 ADDSUB; latched at start
//  op_sub       in   1   ADDSUB only: 1 = subtract; latched at start
//  busy         out  1   high from cycle after accepted start until done
//  done         out  1   one-cycle pulse, operation complete
//  rd_en        out  1   RAM read strobe (data valid on in_data next cycle)
//  rd_addr      out  5   word address
//  rd_sel       out  1   0 = poly A bank, 1 = poly B bank
//  wr_en        out  1   write strobe for datapath out_data
//  wr_addr      out  5   write word address
//  bf_mode      out  2   to datapath mode (latched op_mode)
//  bf_stage     out  3   to datapath stage, aligned with in_data
//  bf_type      out  1   to datapath type, aligned with in_data
//  bf_pre_load  out  1   load A-operand pre-buffer (MULT/ADDSUB)
//  bf_load      out  1   load A/B operand buffers (MULT/ADDSUB)
//  coef_addr    out  8   twiddle ROM address, aligned with in_data
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE, counters 0. Reset mid-operation aborts, no done.
//  - FSM: IDLE -start-> READ -last read-> DRAIN -last write-> READ (next stage) | FIN -> IDLE.
//  - NTT/INTT READ: WORDS consecutive reads, rd_addr = 0..31, rd_sel = 0.
//    bf_stage = stage (NTT 0..6; INTT 0..6), bf_type = 0, coef_addr = {stage, word}, all
//    registered one cycle after rd_en so they align with in_data.
//  - MULT/ADDSUB READ: 2 cycles/word: A read (rd_sel=0) then B read (rd_sel=1), same addr;
//    bf_pre_load aligned with A data, bf_load aligned with B data. bf_stage = word[2:0] for
//    MULT (selects pair slot / coef sign), {2'b0, word[0]} for ADDSUB. bf_type = op_sub.
//    coef_addr = {3'd7, word}.
//  - Write: wr_en/wr_addr = read strobe/addr delayed 1+LAT(mode) cycles (B read only in
//    MULT/ADDSUB). In-place: wr_addr == rd_addr of the issuing read.
//  - DRAIN: no reads; next stage's first read issued the cycle after the stage's last wr_en
//    (read-after-write safe). No overlap of stages.
//  - FIN: done=1 for one cycle the cycle after the final wr_en; busy drops same cycle.
//  - start while busy: ignored, latched mode unchanged. start and reset same cycle: reset wins.
//  - Stage/word counters wrap at their max only via FSM transition, never free-running.
// CONFIGURATION
//  BUTTERFLY_SCHED_PERF_EN defined: adds out port cycle_cnt[15:0] = cycles from start accept
//  to done, held until next start, 0 on reset. Undefined: port and counter absent.
// STRUCTURE
//  Shared package/header: mode encodings (NTT/INTT/MULT/ADDSUB), stage counts per mode,
//  latency constants. Sub-module: sched_delay_line (parameterised depth shift register
//  carrying {valid, addr}), one instance per latency selected by mode mux.
// TESTING
//  1 NTT, LAT_NTT=7: start@0 -> reads cyc 1..32 stage 0, last wr_en cyc 40, stage 1 read
//    cyc 41; done at cyc 281, wr count 224, wr_addr sequence 0..31 x7.
//  2 MULT, LAT_MULT=11: 64 reads alternating rd_sel 0/1; bf_load 32 pulses; done cyc 77.
//  3 ADDSUB op_sub=1: bf_type=1 throughout, bf_stage alternates 0/1, 32 writes, done cyc 69.
//  4 start pulse at cyc 10 during NTT: ignored; op_mode still NTT, done timing unchanged.
//  5 rst_n low during stage 3 DRAIN: next cycle all outputs 0, no done; new start works.
//  6 INTT coef_addr check: stage 2 word 5 -> coef_addr = 8'h45 aligned with bf_stage=2.

Source files
------------

// File: rtl/butterfly_sched_pkg.sv
// -----------------------------------------------------------------------------
// butterfly_sched_pkg
// Shared definitions for the butterfly scheduler: operation mode encodings,
// FSM state encoding, default datapath latencies, word/stage geometry and
// small helpers that derive per-mode properties.
// -----------------------------------------------------------------------------
package butterfly_sched_pkg;

    // Operation modes as seen on op_mode / bf_mode
    typedef enum logic [1:0] {
        MODE_NTT    = 2'd0,
        MODE_INTT   = 2'd1,
        MODE_MULT   = 2'd2,
        MODE_ADDSUB = 2'd3
    } mode_e;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // Default datapath latencies (in_data -> out_data) and polynomial geometry
    localparam int LAT_NTT_DEF    = 7;
    localparam int LAT_MULT_DEF   = 11;
    localparam int LAT_ADDSUB_DEF = 3;
    localparam int WORDS_DEF      = 32;
    localparam int ADDR_W         = 5;
    localparam int STAGE_W        = 3;

    // Index of the final stage: transforms run 7 stages, element-wise ops one pass
    localparam logic [STAGE_W-1:0] NTT_LAST_STAGE  = 3'd6;
    localparam logic [STAGE_W-1:0] PASS_LAST_STAGE = 3'd0;

    // Twiddle ROM page used by the element-wise modes
    localparam logic [STAGE_W-1:0] PAIR_COEF_PAGE = 3'd7;

    // Element-wise modes read an A word and a B word per address
    function automatic logic is_pair(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Last stage index for a given mode
    function automatic logic [STAGE_W-1:0] last_stage(input logic [1:0] mode);
        logic [STAGE_W-1:0] ls;
        case (mode)
            MODE_NTT, MODE_INTT: ls = NTT_LAST_STAGE;
            MODE_MULT, MODE_ADDSUB: ls = PASS_LAST_STAGE;
            default: ls = PASS_LAST_STAGE;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/butterfly_sched_delay_line.sv
// -----------------------------------------------------------------------------
// sched_delay_line
// Fixed-depth shift register carrying a {valid, addr} pair. Used to turn a
// read strobe/address into the matching write strobe/address once the data
// has travelled through the butterfly datapath.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     strobe entering the line
//   in_addr      word address travelling with the strobe
//   out_valid    in_valid delayed by DEPTH cycles
//   out_addr     in_addr delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module sched_delay_line #(
    parameter int DEPTH = 7,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_addr,
    output logic         out_valid,
    output logic [W-1:0] out_addr
);

    logic [DEPTH-1:0]        valid_r;
    logic [DEPTH-1:0][W-1:0] addr_r;

    // Shift the {valid, addr} pair one slot per cycle; reset flushes in-flight writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            addr_r  <= {(DEPTH*W){1'b0}};
        end else begin
            valid_r[0] <= in_valid;
            addr_r[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                addr_r[i]  <= addr_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_addr  = addr_r[DEPTH-1];

endmodule

// File: rtl/butterfly_sched.sv
// -----------------------------------------------------------------------------
// butterfly_sched
// Sequencer for the 4-BU butterfly datapath. Walks one 256-coefficient
// polynomial (32 x 96-bit words) through NTT/INTT (7 stages) or MULT/ADDSUB
// (single pass), driving RAM read/write addresses, twiddle ROM address and
// per-word datapath controls, draining the pipeline between stages.
// Optional build macro: BUTTERFLY_SCHED_PERF_EN adds cycle_cnt[15:0].
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              begin operation (ignored while busy)
//   op_mode, op_sub    operation select / subtract flag, latched at start
//   busy, done         operation in progress / one-cycle completion pulse
//   rd_en, rd_addr,    RAM read strobe, word address, bank select
//   rd_sel
//   wr_en, wr_addr     write strobe/address for datapath out_data
//   bf_mode            latched mode to the datapath
//   bf_stage, bf_type  stage / type controls aligned with in_data
//   bf_pre_load,       A pre-buffer and A/B buffer loads (element-wise modes)
//   bf_load
//   coef_addr          twiddle ROM address aligned with in_data
//   cycle_cnt          (perf build) cycles from start accept to done
// -----------------------------------------------------------------------------
module butterfly_sched
    import butterfly_sched_pkg::*;
#(
    parameter int LAT_NTT    = LAT_NTT_DEF,
    parameter int LAT_MULT   = LAT_MULT_DEF,
    parameter int LAT_ADDSUB = LAT_ADDSUB_DEF,
    parameter int WORDS      = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op_mode,
    input  logic        op_sub,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [4:0]  rd_addr,
    output logic        rd_sel,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [1:0]  bf_mode,
    output logic [2:0]  bf_stage,
    output logic        bf_type,
    output logic        bf_pre_load,
    output logic        bf_load,
    output logic [7:0]  coef_addr
`ifdef BUTTERFLY_SCHED_PERF_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    state_e              state_r;
    logic [STAGE_W-1:0]  stage_r;
    logic                sub_r;

    logic                pair_s;
    logic                wr_in_valid_s;
    logic                dl_ntt_valid_s, dl_mult_valid_s, dl_as_valid_s;
    logic [ADDR_W-1:0]   dl_ntt_addr_s, dl_mult_addr_s, dl_as_addr_s;
    logic                dl_valid_s;
    logic [ADDR_W-1:0]   dl_addr_s;

    assign pair_s = is_pair(bf_mode);

    // Only the B read of an A/B pair produces a result word
    assign wr_in_valid_s = rd_en & (~pair_s | rd_sel);

    // Scheduler FSM with registered read-side and aligned datapath controls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            stage_r     <= 3'd0;
            sub_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= 5'd0;
            rd_sel      <= 1'b0;
            bf_mode     <= 2'd0;
            bf_stage    <= 3'd0;
            bf_type     <= 1'b0;
            bf_pre_load <= 1'b0;
            bf_load     <= 1'b0;
            coef_addr   <= 8'd0;
        end else begin
            // Controls describing the word now being read, seen with its data next cycle
            if (rd_en) begin
                if (pair_s) begin
                    bf_stage    <= (bf_mode == MODE_MULT) ? rd_addr[2:0] : {2'b00, rd_addr[0]};
                    bf_type     <= sub_r;
                    coef_addr   <= {PAIR_COEF_PAGE, rd_addr};
                    bf_pre_load <= ~rd_sel;
                    bf_load     <= rd_sel;
                end else begin
                    bf_stage    <= stage_r;
                    bf_type     <= 1'b0;
                    coef_addr   <= {stage_r, rd_addr};
                    bf_pre_load <= 1'b0;
                    bf_load     <= 1'b0;
                end
            end else begin
                bf_stage    <= 3'd0;
                bf_type     <= 1'b0;
                coef_addr   <= 8'd0;
                bf_pre_load <= 1'b0;
                bf_load     <= 1'b0;
            end

            done <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bf_mode <= op_mode;
                        sub_r   <= op_sub;
                        busy    <= 1'b1;
                        stage_r <= 3'd0;
                        rd_en   <= 1'b1;
                        rd_addr <= 5'd0;
                        rd_sel  <= 1'b0;
                        state_r <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (pair_s && !rd_sel) begin
                        // A read done, B read of the same word follows
                        rd_sel <= 1'b1;
                    end else if (rd_addr == LAST_WORD) begin
                        rd_en   <= 1'b0;
                        rd_sel  <= 1'b0;
                        rd_addr <= 5'd0;
                        state_r <= ST_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 5'd1;
                        rd_sel  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Stage ends with its last write; next reads only after it (RAW safe)
                    if (wr_en && (wr_addr == LAST_WORD)) begin
                        if (stage_r == last_stage(bf_mode)) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            stage_r <= 3'd0;
                            state_r <= ST_FIN;
                        end else begin
                            stage_r <= stage_r + 3'd1;
                            rd_en   <= 1'b1;
                            rd_addr <= 5'd0;
                            state_r <= ST_READ;
                        end
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // One delay line per datapath latency; the extra register below supplies the +1
    sched_delay_line #(.DEPTH(LAT_NTT), .W(ADDR_W)) u_dl_ntt (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (wr_in_valid_s),
        .in_addr   (rd_addr),
        .out_valid (dl_ntt_valid_s),
        .out_addr  (dl_ntt_addr_s)
    );

    sched_delay_line #(.DEPTH(LAT_MULT), .W(ADDR_W)) u_dl_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (wr_in_valid_s),
        .in_addr   (rd_addr),
        .out_valid (dl_mult_valid_s),
        .out_addr  (dl_mult_addr_s)
    );

    sched_delay_line #(.DEPTH(LAT_ADDSUB), .W(ADDR_W)) u_dl_addsub (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (wr_in_valid_s),
        .in_addr   (rd_addr),
        .out_valid (dl_as_valid_s),
        .out_addr  (dl_as_addr_s)
    );

    // Pick the delay line matching the latched mode
    always_comb begin
        dl_valid_s = 1'b0;
        dl_addr_s  = 5'd0;
        case (bf_mode)
            MODE_NTT, MODE_INTT: begin
                dl_valid_s = dl_ntt_valid_s;
                dl_addr_s  = dl_ntt_addr_s;
            end
            MODE_MULT: begin
                dl_valid_s = dl_mult_valid_s;
                dl_addr_s  = dl_mult_addr_s;
            end
            MODE_ADDSUB: begin
                dl_valid_s = dl_as_valid_s;
                dl_addr_s  = dl_as_addr_s;
            end
            default: begin
                dl_valid_s = 1'b0;
                dl_addr_s  = 5'd0;
            end
        endcase
    end

    // Registered write strobe/address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= 5'd0;
        end else begin
            wr_en   <= dl_valid_s;
            wr_addr <= dl_addr_s;
        end
    end

`ifdef BUTTERFLY_SCHED_PERF_EN
    // Operation length counter: 1 on the first busy cycle, held after done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= 16'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            cycle_cnt <= 16'd1;
        end else if (busy) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end else begin
            cycle_cnt <= cycle_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_butterfly_sched.sv
module tb_butterfly_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op_mode = 2'd0;
    logic       op_sub = 1'b0;
    logic       busy, done, rd_en, rd_sel, wr_en, bf_type, bf_pre_load, bf_load;
    logic [4:0] rd_addr, wr_addr;
    logic [1:0] bf_mode;
    logic [2:0] bf_stage;
    logic [7:0] coef_addr;
`ifdef BUTTERFLY_SCHED_PERF_EN
    logic [15:0] cycle_cnt;
`endif

    butterfly_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op_mode     (op_mode),
        .op_sub      (op_sub),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_sel      (rd_sel),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .bf_mode     (bf_mode),
        .bf_stage    (bf_stage),
        .bf_type     (bf_type),
        .bf_pre_load (bf_pre_load),
        .bf_load     (bf_load),
        .coef_addr   (coef_addr)
`ifdef BUTTERFLY_SCHED_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Written by the main sequence only
    int         run_id = 0;
    int         t0 = 0;
    logic       mon_on = 1'b0;
    logic [1:0] exp_mode = 2'd0;
    logic       exp_sub = 1'b0;

    // Written by the monitor only
    int         seen_run = 0;
    int         rel;
    int         rd_cnt, rdb_cnt, wr_cnt, busy_cnt, done_cnt, done_t;
    int         load_cnt, pre_cnt, rd_err, wr_seq_err, align_err, mode_err;
    int         first_rd_q[$];
    int         last_wr_q[$];
    logic [4:0] m_addr, exp_wr;
    logic       m_sel;
    logic [2:0] m_stage;
    logic       p_en, p_sel;
    logic [4:0] p_addr;
    logic [2:0] p_stage;
    logic [2:0] e_stage;
    logic       e_type, e_pre, e_load;
    logic [7:0] e_coef;
    logic [7:0] cap_coef;
    logic [2:0] cap_stage;
    logic       pm;

    // Reference model of the read sequence and aligned controls, sampled mid-cycle
    always @(negedge clk) begin
        if (run_id != seen_run) begin
            seen_run = run_id;
            rd_cnt = 0; rdb_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_t = -1;
            load_cnt = 0; pre_cnt = 0; rd_err = 0; wr_seq_err = 0; align_err = 0; mode_err = 0;
            first_rd_q.delete();
            last_wr_q.delete();
            m_addr = 5'd0; m_sel = 1'b0; m_stage = 3'd0; exp_wr = 5'd0;
            p_en = 1'b0; p_sel = 1'b0; p_addr = 5'd0; p_stage = 3'd0;
            cap_coef = 8'd0; cap_stage = 3'd0;
        end
        if (mon_on) begin
            rel = cyc - t0;
            pm = exp_mode[1];
            if (busy) busy_cnt++;
            if (busy && (bf_mode !== exp_mode)) mode_err++;
            if (done) begin
                done_cnt++;
                done_t = rel;
            end
            if (p_en) begin
                if (pm) begin
                    e_stage = (exp_mode == 2'd2) ? p_addr[2:0] : {2'b00, p_addr[0]};
                    e_type  = exp_sub;
                    e_coef  = {3'd7, p_addr};
                    e_pre   = ~p_sel;
                    e_load  = p_sel;
                end else begin
                    e_stage = p_stage;
                    e_type  = 1'b0;
                    e_coef  = {p_stage, p_addr};
                    e_pre   = 1'b0;
                    e_load  = 1'b0;
                end
                if ({bf_stage, bf_type, coef_addr, bf_pre_load, bf_load} !==
                    {e_stage, e_type, e_coef, e_pre, e_load}) align_err++;
                if (!pm && (p_stage == 3'd2) && (p_addr == 5'd5)) begin
                    cap_coef  = coef_addr;
                    cap_stage = bf_stage;
                end
            end else if (bf_pre_load || bf_load) begin
                align_err++;
            end
            if (bf_load) load_cnt++;
            if (bf_pre_load) pre_cnt++;
            p_en = rd_en;
            if (rd_en) begin
                rd_cnt++;
                if (rd_sel) rdb_cnt++;
                if ((rd_addr !== m_addr) || (rd_sel !== m_sel)) rd_err++;
                if ((rd_addr == 5'd0) && !rd_sel) first_rd_q.push_back(rel);
                p_addr = m_addr; p_sel = m_sel; p_stage = m_stage;
                if (pm) begin
                    if (m_sel) m_addr = m_addr + 5'd1;
                    m_sel = ~m_sel;
                end else begin
                    m_addr = m_addr + 5'd1;
                    if (m_addr == 5'd0) m_stage = m_stage + 3'd1;
                end
            end
            if (wr_en) begin
                wr_cnt++;
                if (wr_addr !== exp_wr) wr_seq_err++;
                exp_wr = exp_wr + 5'd1;
                if (wr_addr == 5'd31) last_wr_q.push_back(rel);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // Start an operation, optionally pulse a stray start at relative cycle inj
    task automatic run_op(input logic [1:0] m, input logic s, input int inj, input int budget);
        run_id++;
        exp_mode = m;
        exp_sub  = s;
        mon_on   = 1'b1;
        op_mode  = m;
        op_sub   = s;
        start    = 1'b1;
        t0       = cyc;
        step(1);
        start   = 1'b0;
        op_mode = ~m;
        op_sub  = ~s;
        for (int i = 1; i < budget && done_cnt == 0; i++) begin
            start = (i == inj);
            if (i == inj) op_mode = 2'd2;
            step(1);
        end
        start = 1'b0;
        step(4);
        chk("done_pulses", done_cnt, 1);
        mon_on = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with start held high: reset must win
        rst_n = 1'b0; start = 1'b1; op_mode = 2'd2;
        step(3);
        chk("reset_outputs", {busy, done, rd_en, rd_addr, rd_sel, wr_en, wr_addr, bf_mode,
                              bf_stage, bf_type, bf_pre_load, bf_load, coef_addr}, 0);
        start = 1'b0; op_mode = 2'd0; rst_n = 1'b1;
        step(2);
        chk("idle_after_reset", {busy, done, rd_en, wr_en}, 0);

        // NTT full run
        run_op(2'd0, 1'b0, -1, 400);
        chk("ntt_first_read", q_at(first_rd_q, 0), 1);
        chk("ntt_stage1_read", q_at(first_rd_q, 1), 41);
        chk("ntt_stage6_read", q_at(first_rd_q, 6), 241);
        chk("ntt_last_wr_s0", q_at(last_wr_q, 0), 40);
        chk("ntt_done_cycle", done_t, 281);
        chk("ntt_rd_count", rd_cnt, 224);
        chk("ntt_wr_count", wr_cnt, 224);
        chk("ntt_rd_seq_err", rd_err, 0);
        chk("ntt_wr_seq_err", wr_seq_err, 0);
        chk("ntt_align_err", align_err, 0);
        chk("ntt_busy_cycles", busy_cnt, 280);
        chk("ntt_mode_err", mode_err, 0);
`ifdef BUTTERFLY_SCHED_PERF_EN
        chk("ntt_cycle_cnt", cycle_cnt, 281);
`endif

        // MULT
        run_op(2'd2, 1'b0, -1, 200);
        chk("mult_rd_count", rd_cnt, 64);
        chk("mult_rdb_count", rdb_cnt, 32);
        chk("mult_load_count", load_cnt, 32);
        chk("mult_preload_count", pre_cnt, 32);
        chk("mult_wr_count", wr_cnt, 32);
        chk("mult_wr_seq_err", wr_seq_err, 0);
        chk("mult_rd_seq_err", rd_err, 0);
        chk("mult_align_err", align_err, 0);
        chk("mult_done_cycle", done_t, 77);
        chk("mult_busy_cycles", busy_cnt, 76);

        // Stray start during NTT is ignored
        run_op(2'd0, 1'b0, 10, 400);
        chk("ign_done_cycle", done_t, 281);
        chk("ign_mode_err", mode_err, 0);
        chk("ign_wr_count", wr_cnt, 224);

        // INTT twiddle alignment at stage 2 word 5
        run_op(2'd1, 1'b0, -1, 400);
        chk("intt_coef_s2w5", cap_coef, 8'h45);
        chk("intt_stage_s2w5", cap_stage, 3'd2);
        chk("intt_align_err", align_err, 0);
        chk("intt_done_cycle", done_t, 281);

        // Reset during stage 3 drain aborts the run
        run_id++;
        exp_mode = 2'd0; exp_sub = 1'b0; mon_on = 1'b1;
        op_mode = 2'd0; op_sub = 1'b0; start = 1'b1; t0 = cyc;
        step(1);
        start = 1'b0;
        step(154);
        chk("abort_in_drain", {busy, rd_en}, 2'b10);
        rst_n = 1'b0;
        step(1);
        chk("abort_outputs_zero", {busy, done, rd_en, rd_addr, rd_sel, wr_en, wr_addr, bf_mode,
                                   bf_stage, bf_type, bf_pre_load, bf_load, coef_addr}, 0);
        rst_n = 1'b1;
        step(20);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_write", {wr_en, busy}, 0);
        mon_on = 1'b0;

        // ADDSUB subtract after the abort
        run_op(2'd3, 1'b1, -1, 200);
        chk("as_wr_count", wr_cnt, 32);
        chk("as_load_count", load_cnt, 32);
        chk("as_align_err", align_err, 0);
        chk("as_rd_seq_err", rd_err, 0);
        chk("as_done_cycle", done_t, 69);
        chk("as_busy_cycles", busy_cnt, 68);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
